// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder.
// Build option: SPIKE_DECODER_SYNC_EN (see spike_event_detect).
package spike_dec_pkg;

   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned WCNT_W    = 24;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_e;

   // Saturating increment; ovf is set when v is already at maxv.
   function automatic logic [31:0] sat_inc(
      input  logic [31:0] v,
      input  logic [31:0] maxv,
      output logic        ovf
   );
      ovf     = (v >= maxv);
      sat_inc = ovf ? maxv : v + 32'd1;
   endfunction

endpackage

// File: rtl/spike_dec_if.sv
// Run/spike inputs and rate/ISI readout of the spike rate decoder.
// Build option: SPIKE_DECODER_SYNC_EN does not change this bundle.
interface spike_dec_if
   import spike_dec_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
);

   logic             ena;
   logic             spike_in;
   logic [CNT_W-1:0] rate;
   logic             rate_valid;
   logic             rate_sat;
   logic [CNT_W-1:0] isi;
   logic             isi_valid;
   logic             running;

   modport master (
      output ena,
      output spike_in,
      input  rate,
      input  rate_valid,
      input  rate_sat,
      input  isi,
      input  isi_valid,
      input  running
   );

   modport slave (
      input  ena,
      input  spike_in,
      output rate,
      output rate_valid,
      output rate_sat,
      output isi,
      output isi_valid,
      output running
   );

endinterface

// File: rtl/spike_event_detect.sv
// Per-cycle spike event; with SPIKE_DECODER_SYNC_EN defined the line
// first passes a reset-to-0 two-flop synchronizer.
module spike_event_detect (
`ifdef SPIKE_DECODER_SYNC_EN
   input  logic clk,
   input  logic rst_n,
`endif
   input  logic spike_i,
   output logic evt_o
);

`ifdef SPIKE_DECODER_SYNC_EN
   logic s0_q;
   logic s1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q <= 1'b0;
         s1_q <= 1'b0;
      end else begin
         s0_q <= spike_i;
         s1_q <= s0_q;
      end
   end

   assign evt_o = s1_q;
`else
   assign evt_o = spike_i;
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike counter plus inter-spike interval meter.
// Build option: SPIKE_DECODER_SYNC_EN adds a 2-flop input synchronizer.
module spike_rate_decoder
   import spike_dec_pkg::*;
#(
   parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   spike_dec_if.slave  bus
);

   localparam logic [31:0]       MAXV  = 32'((64'd1 << CNT_W) - 64'd1);
   localparam logic [CNT_W-1:0]  CMAX  = {CNT_W{1'b1}};
   localparam logic [WCNT_W-1:0] WLAST = WINDOW_CYCLES - 24'd1;

   state_e            state_q;
   logic [WCNT_W-1:0] wcnt_q;
   logic [WCNT_W-1:0] wcnt_d;
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  acc_d;
   logic [CNT_W-1:0]  acc_inc;
   logic [CNT_W-1:0]  icnt_q;
   logic [CNT_W-1:0]  icnt_d;
   logic [CNT_W-1:0]  rate_q;
   logic [CNT_W-1:0]  isi_q;
   logic              sat_w_q;
   logic              sat_w_d;
   logic              seen_q;
   logic              rate_sat_q;
   logic              rate_valid_q;
   logic              isi_valid_q;
   logic              running_q;
   logic              evt;
   logic              inc_ovf;
   logic              hit;
   logic              wclose;

   spike_event_detect u_evt (
`ifdef SPIKE_DECODER_SYNC_EN
      .clk     (clk),
      .rst_n   (rst_n),
`endif
      .spike_i (bus.spike_in),
      .evt_o   (evt)
   );

   always_comb begin
      inc_ovf = 1'b0;
      acc_inc = CNT_W'(sat_inc(32'(acc_q), MAXV, inc_ovf));
      hit     = evt & inc_ovf;
      acc_d   = evt ? acc_inc : acc_q;
      sat_w_d = sat_w_q | hit;
      wclose  = (wcnt_q == WLAST);
      wcnt_d  = wclose ? '0 : wcnt_q + 24'd1;
      if (evt)
         icnt_d = CNT_W'(1);
      else if (icnt_q == CMAX)
         icnt_d = icnt_q;
      else
         icnt_d = icnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wcnt_q       <= '0;
         acc_q        <= '0;
         sat_w_q      <= 1'b0;
         icnt_q       <= '0;
         seen_q       <= 1'b0;
         rate_q       <= '0;
         rate_sat_q   <= 1'b0;
         rate_valid_q <= 1'b0;
         isi_q        <= '0;
         isi_valid_q  <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         rate_valid_q <= 1'b0;
         isi_valid_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               wcnt_q  <= '0;
               acc_q   <= '0;
               sat_w_q <= 1'b0;
               icnt_q  <= '0;
               seen_q  <= 1'b0;
               if (bus.ena) begin
                  state_q   <= ST_COUNT;
                  running_q <= 1'b1;
               end
            end
            ST_COUNT: begin
               if (!bus.ena) begin
                  // Abort discards the partial window and ISI history.
                  state_q   <= ST_IDLE;
                  running_q <= 1'b0;
                  wcnt_q    <= '0;
                  acc_q     <= '0;
                  sat_w_q   <= 1'b0;
                  icnt_q    <= '0;
                  seen_q    <= 1'b0;
               end else begin
                  wcnt_q <= wcnt_d;
                  icnt_q <= icnt_d;
                  if (wclose) begin
                     rate_q       <= acc_d;
                     rate_sat_q   <= sat_w_d;
                     rate_valid_q <= 1'b1;
                     acc_q        <= '0;
                     sat_w_q      <= 1'b0;
                  end else begin
                     acc_q   <= acc_d;
                     sat_w_q <= sat_w_d;
                  end
                  if (evt) begin
                     seen_q <= 1'b1;
                     if (seen_q) begin
                        isi_q       <= icnt_q;
                        isi_valid_q <= 1'b1;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.rate       = rate_q;
   assign bus.rate_valid = rate_valid_q;
   assign bus.rate_sat   = rate_sat_q;
   assign bus.isi        = isi_q;
   assign bus.isi_valid  = isi_valid_q;
   assign bus.running    = running_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: CNT_W=8 and CNT_W=4 instances, window 16.
// Honours SPIKE_DECODER_SYNC_EN through the event latency LAT.
module tb_spike_rate_decoder;

   localparam int W = 16;
`ifdef SPIKE_DECODER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   logic spike = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   spike_dec_if #(.CNT_W(8)) bus8 ();
   spike_dec_if #(.CNT_W(4)) bus4 ();

   assign bus8.ena      = ena;
   assign bus8.spike_in = spike;
   assign bus4.ena      = ena;
   assign bus4.spike_in = spike;

   spike_rate_decoder #(.WINDOW_CYCLES(24'd16), .CNT_W(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   spike_rate_decoder #(.WINDOW_CYCLES(24'd16), .CNT_W(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   function automatic int mn(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Model: absolute COUNT-cycle index k, event count per window,
   // ISI as difference of event indices since the last run start.
   bit m_run = 0, m_have = 0, m_ev = 0, s0 = 0, s1 = 0;
   int m_k = 0, m_cnt = 0, m_last = 0;
   int ex_rate = 0, ex_isi = 0;
   bit ex_rv = 0, ex_iv = 0, ex_run = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_run = 0; ex_rate = 0; ex_isi = 0;
         ex_rv = 0; ex_iv = 0; ex_run = 0;
         s0 = 0; s1 = 0;
      end else begin
         m_ev = (LAT == 2) ? s1 : spike;
         s1 = s0;
         s0 = spike;
         ex_rv = 0;
         ex_iv = 0;
         if (!m_run) begin
            if (ena) begin
               m_run = 1; m_k = 0; m_cnt = 0; m_have = 0;
            end
         end else if (!ena) begin
            m_run = 0;
         end else begin
            if (m_ev) begin
               m_cnt++;
               if (m_have) begin
                  ex_isi = m_k - m_last;
                  ex_iv = 1;
               end
               m_last = m_k;
               m_have = 1;
            end
            if (m_k % W == W - 1) begin
               ex_rate = m_cnt;
               ex_rv = 1;
               m_cnt = 0;
            end
            m_k++;
         end
         ex_run = m_run;
      end
   end

   initial forever begin
      @(posedge clk);
      #3;
      chk("run8", int'(bus8.running), int'(ex_run));
      chk("rv8", int'(bus8.rate_valid), int'(ex_rv));
      chk("rate8", int'(bus8.rate), mn(ex_rate, 255));
      chk("sat8", int'(bus8.rate_sat), int'(ex_rate > 255));
      chk("isi8", int'(bus8.isi), mn(ex_isi, 255));
      chk("iv8", int'(bus8.isi_valid), int'(ex_iv));
      chk("run4", int'(bus4.running), int'(ex_run));
      chk("rv4", int'(bus4.rate_valid), int'(ex_rv));
      chk("rate4", int'(bus4.rate), mn(ex_rate, 15));
      chk("sat4", int'(bus4.rate_sat), int'(ex_rate > 15));
      chk("isi4", int'(bus4.isi), mn(ex_isi, 15));
      chk("iv4", int'(bus4.isi_valid), int'(ex_iv));
   end

   // Event plans per window; spike_in is driven LAT cycles ahead.
   logic [15:0] plan[$];
   int          e8[$];
   int          e4[$];
   int          s4[$];

   task automatic run_seq();
      int n;
      n = plan.size();
      for (int c = 0; c < n * W; c++) begin
         int j;
         j = c + LAT;
         spike = (j < n * W) ? plan[j / W][j % W] : 1'b0;
         @(negedge clk);
         if (c % W == W - 1) begin
            chk("win_rv", int'(bus8.rate_valid), 1);
            chk("win_rate8", int'(bus8.rate), e8[c / W]);
            chk("win_rate4", int'(bus4.rate), e4[c / W]);
            chk("win_sat4", int'(bus4.rate_sat), s4[c / W]);
         end
      end
      spike = 1'b0;
   endtask

   int          isiq[$];
   int          n_iv;
   int          n_rv;
   logic [15:0] pat;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_rate", int'(bus8.rate), 0);
      chk("rst_sat", int'(bus8.rate_sat), 0);
      chk("rst_isi", int'(bus8.isi), 0);
      chk("rst_rv", int'(bus8.rate_valid), 0);
      chk("rst_iv", int'(bus8.isi_valid), 0);
      chk("rst_run", int'(bus8.running), 0);

      rst_n = 1'b1;
      ena = 1'b1;
      @(negedge clk);
      chk("run_rise", int'(bus8.running), 1);

      plan = '{16'h1494, 16'h0000, 16'h8000, 16'h0000, 16'hFFFF, 16'h0000};
      e8 = '{5, 0, 1, 0, 16, 0};
      e4 = '{5, 0, 1, 0, 15, 0};
      s4 = '{0, 0, 0, 0, 1, 0};
      run_seq();

      ena = 1'b0;
      repeat (3) @(negedge clk);
      ena = 1'b1;
      @(negedge clk);
      pat = 16'h0064;
      isiq = {};
      for (int c = 0; c < 10; c++) begin
         spike = pat[c + LAT];
         @(negedge clk);
         if (bus8.isi_valid) isiq.push_back(int'(bus8.isi));
      end
      spike = 1'b0;
      chk("isi_npulse", isiq.size(), 2);
      chk("isi_first", (isiq.size() > 0) ? isiq[0] : -1, 3);
      chk("isi_second", (isiq.size() > 1) ? isiq[1] : -1, 1);

      ena = 1'b0;
      n_rv = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus8.rate_valid) n_rv++;
      end
      chk("abort_no_rv", n_rv, 0);
      ena = 1'b1;
      @(negedge clk);
      pat = 16'h0008;
      n_iv = 0;
      n_rv = 0;
      for (int c = 0; c < W; c++) begin
         spike = pat[c + LAT];
         @(negedge clk);
         if (bus8.isi_valid) n_iv++;
         if (bus8.rate_valid) n_rv++;
      end
      chk("restart_no_iv", n_iv, 0);
      chk("restart_isi", int'(bus8.isi), 1);
      chk("restart_rv", n_rv, 1);
      chk("restart_rate", int'(bus8.rate), 1);

      pat = 16'h0024;
      for (int c = 0; c < 8; c++) begin
         spike = pat[c + LAT];
         @(negedge clk);
      end
      spike = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstab_rate", int'(bus8.rate), 0);
      chk("rstab_run", int'(bus8.running), 0);
      chk("rstab_isi", int'(bus8.isi), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstab_rerun", int'(bus8.running), 1);
      plan = '{16'h0204, 16'h0000};
      e8 = '{2, 0};
      e4 = '{2, 0};
      s4 = '{0, 0};
      run_seq();

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
